// File: rtl/flash_qspi_arbiter.sv
// flash_qspi_arbiter
// Shares one QSPI flash read port between two requesters.
// Ownership is granted in IDLE and held for the whole burst. Once the owner
// lets go, any outstanding word is drained to it. The device is then disabled
// for RELEASE_CYCLES cycles before the next arbitration.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   reqN_enable/address/changeAddress/requestData   requester N inputs (N=0,1)
//   reqN_readData/readDataValid/granted             requester N outputs
//   qspi_enable/address/changeAddress/requestData   towards the QSPI device
//   qspi_readData/readDataValid                     from the QSPI device
module flash_qspi_arbiter #(
  parameter int RELEASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_enable,
  input  logic [23:0] req0_address,
  input  logic        req0_changeAddress,
  input  logic        req0_requestData,
  output logic [31:0] req0_readData,
  output logic        req0_readDataValid,
  output logic        req0_granted,
  input  logic        req1_enable,
  input  logic [23:0] req1_address,
  input  logic        req1_changeAddress,
  input  logic        req1_requestData,
  output logic [31:0] req1_readData,
  output logic        req1_readDataValid,
  output logic        req1_granted,
  output logic        qspi_enable,
  output logic [23:0] qspi_address,
  output logic        qspi_changeAddress,
  output logic        qspi_requestData,
  input  logic [31:0] qspi_readData,
  input  logic        qspi_readDataValid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int CW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  state_t        state_r, state_s;
  logic          owner_r, owner_s;
  logic          last_owner_r;
  logic          pending_r, pending_s;
  logic          first_r;
  logic [CW-1:0] rel_cnt_r;
  logic [1:0]    granted_r;
  logic          issue_s;
  logic          own_en_s;
  logic [23:0]   own_addr_s;
  logic          own_ca_s;
  logic          own_rd_s;
  logic          fwd_s;

  // Owner-side input mux; the non-owner's inputs never reach the device.
  always_comb begin
    own_en_s   = owner_r ? req1_enable        : req0_enable;
    own_addr_s = owner_r ? req1_address       : req0_address;
    own_ca_s   = owner_r ? req1_changeAddress : req0_changeAddress;
    own_rd_s   = owner_r ? req1_requestData   : req0_requestData;
  end

  // A request issued and a word returned in the same cycle leaves one word
  // still outstanding, so the set term wins over the clear term.
  always_comb begin
    issue_s   = (state_r == GRANT) && !first_r && own_rd_s;
    pending_s = issue_s | (pending_r & ~qspi_readDataValid);
  end

  // Next-state logic and device-side outputs.
  always_comb begin
    state_s            = state_r;
    owner_s            = owner_r;
    qspi_enable        = 1'b0;
    qspi_address       = 24'h000000;
    qspi_changeAddress = 1'b0;
    qspi_requestData   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_enable || req1_enable) begin
          state_s = GRANT;
          // On a tie the side that did not own the device last time wins.
          if (req0_enable && req1_enable) begin
            owner_s = ~last_owner_r;
          end else begin
            owner_s = req1_enable;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        qspi_enable  = 1'b1;
        qspi_address = own_addr_s;
        // The first cycle of a grant always restarts the device at the
        // owner's address, whatever the owner is driving.
        if (first_r) begin
          qspi_changeAddress = 1'b1;
        end else begin
          qspi_changeAddress = own_ca_s;
          qspi_requestData   = own_rd_s;
        end
        if (!own_en_s) begin
          state_s = pending_s ? DRAIN : RELEASE;
        end else begin
          state_s = GRANT;
        end
      end
      DRAIN: begin
        qspi_enable  = 1'b1;
        qspi_address = own_addr_s;
        if (qspi_readDataValid) begin
          state_s = RELEASE;
        end else begin
          state_s = DRAIN;
        end
      end
      RELEASE: begin
        if (rel_cnt_r == REL_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Returned words go to the current (or draining) owner only.
  always_comb begin
    fwd_s              = (state_r == GRANT) || (state_r == DRAIN);
    req0_readData      = qspi_readData;
    req1_readData      = qspi_readData;
    req0_readDataValid = fwd_s & qspi_readDataValid & ~owner_r;
    req1_readDataValid = fwd_s & qspi_readDataValid & owner_r;
    req0_granted       = granted_r[0];
    req1_granted       = granted_r[1];
  end

  // State, ownership history, outstanding-word flag and release counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      pending_r    <= 1'b0;
      first_r      <= 1'b0;
      rel_cnt_r    <= '0;
      granted_r    <= 2'b00;
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      pending_r <= pending_s;
      first_r   <= (state_r == IDLE) && (state_s == GRANT);
      if ((state_r == IDLE) && (state_s == GRANT)) begin
        last_owner_r <= owner_s;
      end else begin
        last_owner_r <= last_owner_r;
      end
      if ((state_r == RELEASE) && (rel_cnt_r != REL_LAST)) begin
        rel_cnt_r <= rel_cnt_r + CW'(1);
      end else begin
        rel_cnt_r <= '0;
      end
      granted_r[0] <= (state_s == GRANT) && !owner_s;
      granted_r[1] <= (state_s == GRANT) && owner_s;
    end
  end

endmodule

// File: tb/tb_flash_qspi_arbiter.sv
// Directed bench for flash_qspi_arbiter (RELEASE_CYCLES = 2).
module tb_flash_qspi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_enable, req0_changeAddress, req0_requestData;
  logic [23:0] req0_address;
  logic [31:0] req0_readData;
  logic        req0_readDataValid, req0_granted;
  logic        req1_enable, req1_changeAddress, req1_requestData;
  logic [23:0] req1_address;
  logic [31:0] req1_readData;
  logic        req1_readDataValid, req1_granted;
  logic        qspi_enable, qspi_changeAddress, qspi_requestData;
  logic [23:0] qspi_address;
  logic [31:0] qspi_readData;
  logic        qspi_readDataValid;

  int vectors = 0;
  int miscompares = 0;

  flash_qspi_arbiter #(.RELEASE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0_enable(req0_enable), .req0_address(req0_address),
    .req0_changeAddress(req0_changeAddress), .req0_requestData(req0_requestData),
    .req0_readData(req0_readData), .req0_readDataValid(req0_readDataValid),
    .req0_granted(req0_granted),
    .req1_enable(req1_enable), .req1_address(req1_address),
    .req1_changeAddress(req1_changeAddress), .req1_requestData(req1_requestData),
    .req1_readData(req1_readData), .req1_readDataValid(req1_readDataValid),
    .req1_granted(req1_granted),
    .qspi_enable(qspi_enable), .qspi_address(qspi_address),
    .qspi_changeAddress(qspi_changeAddress), .qspi_requestData(qspi_requestData),
    .qspi_readData(qspi_readData), .qspi_readDataValid(qspi_readDataValid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_en(input int o, input logic v);
    if (o == 1) req1_enable = v; else req0_enable = v;
  endtask

  task automatic set_rd(input int o, input logic v);
    if (o == 1) req1_requestData = v; else req0_requestData = v;
  endtask

  initial begin
    int who;
    rst = 1'b1;
    req0_enable = 1'b0; req0_address = 24'h000000; req0_changeAddress = 1'b0; req0_requestData = 1'b0;
    req1_enable = 1'b0; req1_address = 24'h000000; req1_changeAddress = 1'b0; req1_requestData = 1'b0;
    qspi_readData = 32'h12345678;
    qspi_readDataValid = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_enable", {31'd0, qspi_enable}, 32'd0);
    chk("rst_ca", {31'd0, qspi_changeAddress}, 32'd0);
    chk("rst_rd", {31'd0, qspi_requestData}, 32'd0);
    chk("rst_addr", {8'd0, qspi_address}, 32'd0);
    chk("rst_granted", {30'd0, req1_granted, req0_granted}, 32'd0);
    chk("rst_valid", {30'd0, req1_readDataValid, req0_readDataValid}, 32'd0);
    rst = 1'b0;
    qspi_readDataValid = 1'b0;
    tick();

    // Single requester: grant and one-cycle address restart
    req0_enable = 1'b1;
    req0_address = 24'h001000;
    tick();
    chk("g0_granted0", {31'd0, req0_granted}, 32'd1);
    chk("g0_granted1", {31'd0, req1_granted}, 32'd0);
    chk("g0_enable", {31'd0, qspi_enable}, 32'd1);
    chk("g0_ca_first", {31'd0, qspi_changeAddress}, 32'd1);
    chk("g0_addr", {8'd0, qspi_address}, 32'h00001000);
    chk("g0_rd_first", {31'd0, qspi_requestData}, 32'd0);
    tick();
    chk("g0_ca_second", {31'd0, qspi_changeAddress}, 32'd0);
    // Pass-through of owner requestData; non-owner inputs ignored
    req0_requestData = 1'b1;
    req1_changeAddress = 1'b1;
    req1_address = 24'hABCDEF;
    #1;
    chk("pass_rd", {31'd0, qspi_requestData}, 32'd1);
    chk("iso_ca", {31'd0, qspi_changeAddress}, 32'd0);
    chk("iso_addr", {8'd0, qspi_address}, 32'h00001000);
    tick();
    // Owner drops enable one cycle after the request; word outstanding
    req0_requestData = 1'b0;
    req0_enable = 1'b0;
    req1_changeAddress = 1'b0;
    req1_requestData = 1'b1;
    #1;
    chk("iso_rd", {31'd0, qspi_requestData}, 32'd0);
    tick();
    chk("drain_enable", {31'd0, qspi_enable}, 32'd1);
    chk("drain_granted0", {31'd0, req0_granted}, 32'd0);
    chk("drain_rd", {31'd0, qspi_requestData}, 32'd0);
    tick();
    chk("drain_enable3", {31'd0, qspi_enable}, 32'd1);
    tick();
    chk("drain_enable4", {31'd0, qspi_enable}, 32'd1);
    tick();
    qspi_readData = 32'hDEADBEEF;
    qspi_readDataValid = 1'b1;
    #1;
    chk("drain_v0", {31'd0, req0_readDataValid}, 32'd1);
    chk("drain_d0", req0_readData, 32'hDEADBEEF);
    chk("drain_v1", {31'd0, req1_readDataValid}, 32'd0);
    chk("drain_d1", req1_readData, 32'hDEADBEEF);
    chk("drain_enable5", {31'd0, qspi_enable}, 32'd1);
    tick();
    qspi_readDataValid = 1'b0;
    req1_requestData = 1'b0;
    chk("rel_enable1", {31'd0, qspi_enable}, 32'd0);
    tick();
    chk("rel_enable2", {31'd0, qspi_enable}, 32'd0);
    tick();
    chk("idle_enable", {31'd0, qspi_enable}, 32'd0);

    // Simultaneous request after reset: requester 0 first, then 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_enable = 1'b1; req0_address = 24'hAAAAAA;
    req1_enable = 1'b1; req1_address = 24'h555555;
    tick();
    chk("sim_granted", {30'd0, req1_granted, req0_granted}, 32'd1);
    chk("sim_addr0", {8'd0, qspi_address}, 32'h00AAAAAA);
    tick();
    req0_enable = 1'b0;
    tick();
    chk("sim_rel_granted", {30'd0, req1_granted, req0_granted}, 32'd0);
    chk("sim_rel_enable", {31'd0, qspi_enable}, 32'd0);
    tick();
    chk("sim_rel2_enable", {31'd0, qspi_enable}, 32'd0);
    tick();
    chk("sim_idle_granted", {30'd0, req1_granted, req0_granted}, 32'd0);
    tick();
    chk("sim_granted1", {30'd0, req1_granted, req0_granted}, 32'd2);
    chk("sim_addr1", {8'd0, qspi_address}, 32'h00555555);
    chk("sim_ca1", {31'd0, qspi_changeAddress}, 32'd1);
    tick();
    qspi_readData = 32'hCAFEF00D;
    qspi_readDataValid = 1'b1;
    #1;
    chk("own1_v1", {31'd0, req1_readDataValid}, 32'd1);
    chk("own1_v0", {31'd0, req0_readDataValid}, 32'd0);
    qspi_readDataValid = 1'b0;

    // Asynchronous reset in the middle of a grant
    #1;
    rst = 1'b1;
    #1;
    chk("arst_enable", {31'd0, qspi_enable}, 32'd0);
    chk("arst_granted", {30'd0, req1_granted, req0_granted}, 32'd0);
    req0_enable = 1'b0;
    req1_enable = 1'b0;
    qspi_readDataValid = 1'b1;
    tick();
    chk("arst_late_v", {30'd0, req1_readDataValid, req0_readDataValid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("arst_after_v", {30'd0, req1_readDataValid, req0_readDataValid}, 32'd0);
    chk("arst_after_en", {31'd0, qspi_enable}, 32'd0);
    qspi_readDataValid = 1'b0;

    // Fairness: both keep requesting, each owner releases after 4 words
    req0_enable = 1'b1;
    req1_enable = 1'b1;
    for (int b = 0; b < 4; b++) begin
      who = -1;
      for (int k = 0; k < 12 && who < 0; k++) begin
        if (req0_granted) who = 0;
        else if (req1_granted) who = 1;
        else tick();
      end
      chk("fair_order", who, b % 2);
      if (who >= 0) begin
        for (int w = 0; w < 4; w++) begin
          tick();
          set_rd(who, 1'b1);
          tick();
          set_rd(who, 1'b0);
          qspi_readData = 32'h00001000 + w;
          qspi_readDataValid = 1'b1;
          #1;
          chk("fair_word_v", {31'd0, (who == 1) ? req1_readDataValid : req0_readDataValid}, 32'd1);
          tick();
          qspi_readDataValid = 1'b0;
        end
        set_en(who, 1'b0);
        tick();
        set_en(who, 1'b1);
        chk("fair_rel_en", {31'd0, qspi_enable}, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
